// File: rtl/cla_pg_issue_stage.sv
// Registered issue stage for the 4-bit CLA path: opcode -> propagate/generate/carry-in decode,
// a two-entry skid buffer toward the lookahead unit, and carry-flag tracking with a carry interlock.
module cla_pg_issue_stage #(
  parameter int PEND_MAX = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_a,
  input  logic [3:0] in_b,
  input  logic [2:0] in_op,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_p,
  output logic [3:0] out_g,
  output logic       out_cin,
  output logic [2:0] out_op,
  input  logic       cf_we,
  input  logic       cf_in,
  output logic       carry_flag
);

  localparam int PW = $clog2(PEND_MAX + 1);
  localparam logic [PW-1:0] PEND_FULL = PW'(PEND_MAX);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_ADC  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_SBB  = 3'b011;
  localparam logic [2:0] OP_INC  = 3'b100;
  localparam logic [2:0] OP_DEC  = 3'b101;
  localparam logic [2:0] OP_CMP  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  logic            out_valid_q, out_valid_d;
  logic [3:0]      out_p_q, out_p_d, out_g_q, out_g_d;
  logic            out_cin_q, out_cin_d;
  logic [2:0]      out_op_q, out_op_d;
  logic            skid_valid_q, skid_valid_d;
  logic [3:0]      skid_p_q, skid_p_d, skid_g_q, skid_g_d;
  logic            skid_cin_q, skid_cin_d;
  logic [2:0]      skid_op_q, skid_op_d;
  logic [PW-1:0]   pending_q, pending_d;
  logic            carry_flag_q, carry_flag_d;

  logic [3:0]      b_eff;
  logic            cin_dec;
  logic [3:0]      p_dec, g_dec;
  logic            in_produce, in_consume, stall, accept, out_load;
  logic            pend_inc, pend_dec;

  // cin samples the pre-edge carry flag, so a same-cycle write-back is not seen.
  always_comb begin
    b_eff   = in_b;
    cin_dec = 1'b0;
    case (in_op)
      OP_ADD:  begin b_eff = in_b;    cin_dec = 1'b0;         end
      OP_ADC:  begin b_eff = in_b;    cin_dec = carry_flag_q; end
      OP_SUB:  begin b_eff = ~in_b;   cin_dec = 1'b1;         end
      OP_SBB:  begin b_eff = ~in_b;   cin_dec = carry_flag_q; end
      OP_INC:  begin b_eff = 4'b0000; cin_dec = 1'b1;         end
      OP_DEC:  begin b_eff = 4'b1111; cin_dec = 1'b0;         end
      OP_CMP:  begin b_eff = ~in_b;   cin_dec = 1'b1;         end
      OP_PASS: begin b_eff = 4'b0000; cin_dec = 1'b0;         end
      default: begin b_eff = in_b;    cin_dec = 1'b0;         end
    endcase
  end

  assign p_dec = in_a ^ b_eff;
  assign g_dec = in_a & b_eff;

  assign in_produce = (in_op == OP_ADD) | (in_op == OP_ADC) | (in_op == OP_SUB) |
                      (in_op == OP_SBB) | (in_op == OP_CMP);
  assign in_consume = (in_op == OP_ADC) | (in_op == OP_SBB);

  assign stall    = (pending_q == PEND_FULL) | (in_consume & (pending_q != '0));
  assign in_ready = ~skid_valid_q & ~stall;
  assign accept   = in_valid & in_ready;
  assign out_load = ~out_valid_q | out_ready;

  // The skid entry always drains first, and is only filled while the output register is held.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_p_d      = out_p_q;
    out_g_d      = out_g_q;
    out_cin_d    = out_cin_q;
    out_op_d     = out_op_q;
    skid_valid_d = skid_valid_q;
    skid_p_d     = skid_p_q;
    skid_g_d     = skid_g_q;
    skid_cin_d   = skid_cin_q;
    skid_op_d    = skid_op_q;
    if (out_load) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_p_d      = skid_p_q;
        out_g_d      = skid_g_q;
        out_cin_d    = skid_cin_q;
        out_op_d     = skid_op_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_valid_d = 1'b1;
        out_p_d     = p_dec;
        out_g_d     = g_dec;
        out_cin_d   = cin_dec;
        out_op_d    = in_op;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_p_d     = p_dec;
      skid_g_d     = g_dec;
      skid_cin_d   = cin_dec;
      skid_op_d    = in_op;
    end
  end

  assign pend_inc = accept & in_produce;
  assign pend_dec = cf_we & (pending_q != '0);

  always_comb begin
    pending_d = pending_q;
    case ({pend_inc, pend_dec})
      2'b10:   pending_d = pending_q + PW'(1);
      2'b01:   pending_d = pending_q - PW'(1);
      default: pending_d = pending_q;
    endcase
    carry_flag_d = cf_we ? cf_in : carry_flag_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_p_q      <= '0;
      out_g_q      <= '0;
      out_cin_q    <= 1'b0;
      out_op_q     <= '0;
      skid_valid_q <= 1'b0;
      skid_p_q     <= '0;
      skid_g_q     <= '0;
      skid_cin_q   <= 1'b0;
      skid_op_q    <= '0;
      pending_q    <= '0;
      carry_flag_q <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_p_q      <= out_p_d;
      out_g_q      <= out_g_d;
      out_cin_q    <= out_cin_d;
      out_op_q     <= out_op_d;
      skid_valid_q <= skid_valid_d;
      skid_p_q     <= skid_p_d;
      skid_g_q     <= skid_g_d;
      skid_cin_q   <= skid_cin_d;
      skid_op_q    <= skid_op_d;
      pending_q    <= pending_d;
      carry_flag_q <= carry_flag_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_p      = out_p_q;
  assign out_g      = out_g_q;
  assign out_cin    = out_cin_q;
  assign out_op     = out_op_q;
  assign carry_flag = carry_flag_q;

endmodule

// File: tb/tb_cla_pg_issue_stage.sv
// Bench for cla_pg_issue_stage: directed scenarios then random traffic, compared each cycle
// against a queue-based model of the two-entry buffer, pending count and carry flag.
module tb_cla_pg_issue_stage;

  localparam int PEND_MAX = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_a = '0;
  logic [3:0] in_b = '0;
  logic [2:0] in_op = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_p;
  logic [3:0] out_g;
  logic       out_cin;
  logic [2:0] out_op;
  logic       cf_we = 1'b0;
  logic       cf_in = 1'b0;
  logic       carry_flag;

  int vectors = 0;
  int miscompares = 0;

  // Model state: in-flight entries {op, cin, g, p}, oldest first.
  logic [11:0] q_m[$];
  int          pend_m = 0;
  logic        cf_m = 1'b0;

  cla_pg_issue_stage #(.PEND_MAX(PEND_MAX)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_p(out_p), .out_g(out_g), .out_cin(out_cin), .out_op(out_op),
    .cf_we(cf_we), .cf_in(cf_in), .carry_flag(carry_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] model_entry(input logic [2:0] op, input logic [3:0] a,
                                              input logic [3:0] b, input logic cf);
    logic [3:0] bb;
    logic       c;
    case (op)
      3'd0:    begin bb = b;       c = 1'b0; end
      3'd1:    begin bb = b;       c = cf;   end
      3'd2:    begin bb = ~b;      c = 1'b1; end
      3'd3:    begin bb = ~b;      c = cf;   end
      3'd4:    begin bb = 4'h0;    c = 1'b1; end
      3'd5:    begin bb = 4'hF;    c = 1'b0; end
      3'd6:    begin bb = ~b;      c = 1'b1; end
      default: begin bb = 4'h0;    c = 1'b0; end
    endcase
    return {op, c, a & bb, a ^ bb};
  endfunction

  function automatic bit produces(input logic [2:0] op);
    return op inside {3'd0, 3'd1, 3'd2, 3'd3, 3'd6};
  endfunction

  function automatic bit consumes(input logic [2:0] op);
    return op == 3'd1 || op == 3'd3;
  endfunction

  // One clock: check in_ready before the edge, advance the model, check state after the edge.
  task automatic cycle();
    bit          rdy_m, fire, acc;
    logic [11:0] e;
    #2;
    rdy_m = (q_m.size() < 2) && !(pend_m == PEND_MAX || (consumes(in_op) && pend_m != 0));
    check("in_ready", 32'(in_ready), 32'(rdy_m));
    fire = (q_m.size() > 0) && out_ready;
    acc  = in_valid && rdy_m;
    e    = model_entry(in_op, in_a, in_b, cf_m);
    @(posedge clk);
    if (fire) void'(q_m.pop_front());
    if (acc) q_m.push_back(e);
    pend_m = pend_m + ((acc && produces(in_op)) ? 1 : 0) - ((cf_we && pend_m != 0) ? 1 : 0);
    if (cf_we) cf_m = cf_in;
    #1;
    check("out_valid", 32'(out_valid), 32'(q_m.size() > 0));
    check("carry_flag", 32'(carry_flag), 32'(cf_m));
    check("pending", 32'(dut.pending_q), 32'(pend_m));
    if (q_m.size() > 0)
      check("payload", {20'd0, out_op, out_cin, out_g, out_p}, {20'd0, q_m[0]});
  endtask

  task automatic step(input logic v, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                      input logic ordy, input logic we, input logic ci);
    in_valid = v; in_op = op; in_a = a; in_b = b;
    out_ready = ordy; cf_we = we; cf_in = ci;
    cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; cf_we = 1'b0; in_op = 3'd0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q_m.delete();
    pend_m = 0;
    cf_m = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_carry_flag", 32'(carry_flag), 32'd0);
    check("rst_pending", 32'(dut.pending_q), 32'd0);
    check("rst_payload", {20'd0, out_op, out_cin, out_g, out_p}, 32'd0);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    do_reset();

    // ADD 0101+0011
    step(1, 3'd0, 4'b0101, 4'b0011, 1, 0, 0);
    check("add_p", 32'(out_p), 32'b0110);
    check("add_g", 32'(out_g), 32'b0001);
    check("add_cin", 32'(out_cin), 32'd0);
    // SUB 0111-0010, then INC 1111
    step(1, 3'd2, 4'b0111, 4'b0010, 1, 0, 0);
    check("sub_pgc", {27'd0, out_cin, out_p, out_g} >> 0, {27'd0, 1'b1, 4'b1010, 4'b0101});
    step(1, 3'd4, 4'b1111, 4'b0000, 1, 0, 0);
    check("inc_pgc", {27'd0, out_cin, out_p, out_g}, {27'd0, 1'b1, 4'b1111, 4'b0000});
    step(0, 3'd0, 4'h0, 4'h0, 1, 1, 0);
    step(0, 3'd0, 4'h0, 4'h0, 1, 1, 0);

    // Back-pressure: three ADDs against a stalled output, then drain in order
    step(1, 3'd0, 4'h1, 4'h1, 0, 0, 0);
    step(1, 3'd0, 4'h2, 4'h3, 0, 0, 0);
    step(1, 3'd0, 4'h4, 4'h7, 0, 0, 0);
    step(0, 3'd0, 4'h0, 4'h0, 1, 0, 0);
    step(0, 3'd0, 4'h0, 4'h0, 1, 1, 0);
    step(0, 3'd0, 4'h0, 4'h0, 1, 1, 0);

    // Carry interlock: ADC waits for the outstanding ADD carry
    step(1, 3'd0, 4'h3, 4'h5, 1, 0, 0);
    step(1, 3'd1, 4'h6, 4'h2, 1, 0, 0);
    step(1, 3'd1, 4'h6, 4'h2, 1, 1, 1);
    step(1, 3'd1, 4'h6, 4'h2, 1, 0, 0);
    check("adc_cin", 32'(out_cin), 32'd1);
    step(0, 3'd0, 4'h0, 4'h0, 1, 1, 0);

    // Pending limit with SUBs, and simultaneous accept + write-back
    step(1, 3'd2, 4'h9, 4'h1, 1, 0, 0);
    step(1, 3'd2, 4'hA, 4'h2, 1, 0, 0);
    step(1, 3'd2, 4'hB, 4'h3, 1, 0, 0);
    step(1, 3'd2, 4'hC, 4'h4, 1, 0, 0);
    step(1, 3'd2, 4'hC, 4'h4, 1, 1, 0);
    step(1, 3'd2, 4'hD, 4'h5, 1, 1, 1);
    step(1, 3'd2, 4'hE, 4'h6, 1, 0, 0);

    // Fill both entries with pending=2, then reset
    step(0, 3'd0, 4'h0, 4'h0, 1, 1, 0);
    step(1, 3'd4, 4'h8, 4'h0, 0, 0, 0);
    step(1, 3'd5, 4'h3, 4'h0, 0, 0, 0);
    check("full_before_rst", 32'(dut.pending_q), 32'd2);
    do_reset();

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom),
             $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3, 1'($urandom));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
